// File: rtl/vend_pkg.sv
// vend_pkg
//   Shared types and helpers for the vend dispenser: FSM state encoding,
//   change-request codes and the coin-weight decode used when capturing
//   change requests.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VEND = 2'd1,
    ST_HOP  = 2'd2,
    ST_JAM  = 2'd3
  } state_t;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  // Number of 5-unit coins a change code asks for; code 11 is ignored.
  function automatic logic [1:0] chg_weight(input logic [1:0] change);
    case (change)
      CHG_5:   return 2'd1;
      CHG_10:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_sat_counter.sv
// vend_sat_counter
//   Pending-work counter. Each cycle next = cnt + inc - dec in one step,
//   saturating at 2^W-1. A decrement on an empty counter is dropped.
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   inc      in   2  amount to add this cycle (0..2)
//   dec      in   1  remove one unit this cycle
//   cnt      out  W  current count
//   zero     out  1  cnt == 0
//   sat_hit  out  1  this cycle's increment is being truncated by saturation
module vend_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         sat_hit
);

  localparam logic [W+1:0] MAX = {2'b00, {W{1'b1}}};

  // Two extra bits so the raw sum can exceed MAX before clamping.
  logic [W+1:0] sum;

  always_comb begin
    sum = {2'b00, cnt} + {{W{1'b0}}, inc};
    if (dec && (cnt != '0)) begin
      sum = sum - {{(W+1){1'b0}}, 1'b1};
    end
  end

  assign sat_hit = (sum > MAX);
  assign zero    = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (sat_hit) begin
      cnt <= MAX[W-1:0];
    end else begin
      cnt <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/vend_dispenser.sv
// vend_dispenser
//   Queues vend and change requests from the vending FSM and runs the
//   product motor and the 5-unit coin hopper one job at a time. Each coin
//   is its own hopper job; a hopper that never reports a coin within the
//   timeout parks the block in JAM until an operator clear.
// Ports
//   clk                 in   clock, all logic on posedge
//   rst                 in   synchronous active-high reset
//   out                 in   vend request, sampled every cycle
//   change              in   2  change request code (00/01/10/11)
//   hopper_coin_sensed  in   one-cycle pulse per coin ejected
//   jam_clr             in   operator clear of JAM
//   motor_en            out  product motor drive (registered)
//   hopper_en           out  coin hopper drive (registered)
//   busy                out  job active or work pending
//   jam_err             out  high while in JAM
//   ovf_err             out  sticky: a request was lost to saturation
//
//   state | meaning
//   IDLE  | no job; picks next job, vends before coins
//   VEND  | motor on for VEND_CYCLES cycles
//   HOP   | hopper on, waiting for one coin or the timeout
//   JAM   | hopper timed out; actuators off until jam_clr
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int VEND_CYCLES = 16,
  parameter int HOP_TIMEOUT = 64,
  parameter int PEND_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       out,
  input  logic [1:0] change,
  input  logic       hopper_coin_sensed,
  input  logic       jam_clr,
  output logic       motor_en,
  output logic       hopper_en,
  output logic       busy,
  output logic       jam_err,
  output logic       ovf_err
);

  localparam int TMR_MAX = (HOP_TIMEOUT > VEND_CYCLES) ? HOP_TIMEOUT : VEND_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] VEND_LAST = TMR_W'(VEND_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOP_LAST  = TMR_W'(HOP_TIMEOUT - 1);

  state_t state, state_nxt;
  logic [TMR_W-1:0] timer;

  logic [PEND_W-1:0] vend_cnt, coin_cnt;
  logic vend_zero, coin_zero;
  logic vend_sat, coin_sat;
  logic vend_dec, coin_dec;

  vend_sat_counter #(.W(PEND_W)) u_vend_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     ({1'b0, out}),
    .dec     (vend_dec),
    .cnt     (vend_cnt),
    .zero    (vend_zero),
    .sat_hit (vend_sat)
  );

  vend_sat_counter #(.W(PEND_W)) u_coin_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (chg_weight(change)),
    .dec     (coin_dec),
    .cnt     (coin_cnt),
    .zero    (coin_zero),
    .sat_hit (coin_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    vend_dec  = 1'b0;
    coin_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!vend_zero) begin
          state_nxt = ST_VEND;
          vend_dec  = 1'b1;
        end else if (!coin_zero) begin
          state_nxt = ST_HOP;
        end
      end
      ST_VEND: begin
        if (timer == VEND_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HOP: begin
        // A sense on the timeout cycle still counts as a good eject.
        if (hopper_coin_sensed) begin
          coin_dec  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (timer == HOP_LAST) begin
          state_nxt = ST_JAM;
        end
      end
      ST_JAM: begin
        if (jam_clr) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Cleared on any state change so every VEND/HOP entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (state_nxt != state) begin
      timer <= '0;
    end else if ((state == ST_VEND) || (state == ST_HOP)) begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Actuators follow the next state so they switch on the same edge as
  // the state register and drop immediately on a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      motor_en  <= 1'b0;
      hopper_en <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      motor_en  <= (state_nxt == ST_VEND);
      hopper_en <= (state_nxt == ST_HOP);
      ovf_err   <= ovf_err | vend_sat | coin_sat;
    end
  end

  assign busy    = (state != ST_IDLE) || !vend_zero || !coin_zero;
  assign jam_err = (state == ST_JAM);

endmodule
